// File: rtl/mc_defs_pkg.sv
// Shared definitions for the MIPS-lite multi-cycle controller: state, opcode/funct,
// instruction class and datapath select encodings. Optional feature macro: CTRL_PERF_EN.
package mc_defs;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_LUI  = 3'd3;

  localparam logic [1:0] RDST_RT  = 2'd0;
  localparam logic [1:0] RDST_RD  = 2'd1;
  localparam logic [1:0] RDST_RA  = 2'd2;

  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_DM    = 2'd1;
  localparam logic [1:0] WD_PC4   = 2'd2;

  // Register the datapath writes when reg_dst selects RDST_RA (jal link).
  localparam int unsigned RA_IDX  = 31;

  typedef enum logic [3:0] {
    CLS_ILL  = 4'd0,
    CLS_ADDU = 4'd1,
    CLS_SUBU = 4'd2,
    CLS_ORI  = 4'd3,
    CLS_LUI  = 4'd4,
    CLS_LW   = 4'd5,
    CLS_SW   = 4'd6,
    CLS_BEQ  = 4'd7,
    CLS_J    = 4'd8,
    CLS_JAL  = 4'd9,
    CLS_JR   = 4'd10
  } cls_t;

  typedef struct packed {
    logic       enpc;
    logic       npc_sel;
    logic       jsome;
    logic       jr;
    logic       ir_wr;
    logic       rf_wr;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       ext_op;
    logic       dm_rd;
    logic       dm_wr;
    logic       illegal;
  } ctrl_t;

  function automatic logic cls_is_rtype(input cls_t c);
    return (c == CLS_ADDU) || (c == CLS_SUBU);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/funct -> instruction class plus illegal flag.
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output cls_t       o_cls,
  output logic       o_illegal
);

  always_comb begin
    o_cls = CLS_ILL;
    case (i_op)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADDU: o_cls = CLS_ADDU;
          FN_SUBU: o_cls = CLS_SUBU;
          FN_JR:   o_cls = CLS_JR;
          default: o_cls = CLS_ILL;
        endcase
      end
      OP_ORI:  o_cls = CLS_ORI;
      OP_LUI:  o_cls = CLS_LUI;
      OP_LW:   o_cls = CLS_LW;
      OP_SW:   o_cls = CLS_SW;
      OP_BEQ:  o_cls = CLS_BEQ;
      OP_J:    o_cls = CLS_J;
      OP_JAL:  o_cls = CLS_JAL;
      default: o_cls = CLS_ILL;
    endcase
    o_illegal = (o_cls == CLS_ILL);
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-lite main controller (FETCH/DECODE/EXEC/MEM/WB, one state per cycle).
// Optional feature macro: CTRL_PERF_EN adds instr_cnt/stall_cnt performance counters.
module mc_ctrl
  import mc_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        enpc,
  output logic        npc_sel,
  output logic        jsome,
  output logic        jr,
  output logic        ir_wr,
  output logic        rf_wr,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        ext_op,
  output logic        dm_rd,
  output logic        dm_wr,
  output logic        illegal,
  output logic [2:0]  state
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0] instr_cnt,
  output logic [31:0] stall_cnt
`endif
);

  state_t r_state;
  cls_t   r_cls;
  cls_t   w_cls;
  logic   w_dec_illegal;
  ctrl_t  w_ctrl;
  ctrl_t  w_out;

  // The branch decision (zero) is taken inside the IFU; the controller only flags beq.
  logic   w_unused_zero;
  assign w_unused_zero = zero ^ w_dec_illegal;

  mc_decode u_decode (
    .i_op      (op),
    .i_funct   (funct),
    .o_cls     (w_cls),
    .o_illegal (w_dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_cls   <= CLS_ILL;
    end else begin
      case (r_state)
        ST_FETCH: r_state <= ST_DECODE;
        ST_DECODE: begin
          r_cls <= w_cls;
          case (w_cls)
            CLS_J, CLS_JAL, CLS_JR, CLS_ILL: r_state <= ST_FETCH;
            default:                         r_state <= ST_EXEC;
          endcase
        end
        ST_EXEC: begin
          case (r_cls)
            CLS_LW, CLS_SW:                     r_state <= ST_MEM;
            CLS_ADDU, CLS_SUBU, CLS_ORI, CLS_LUI: r_state <= ST_WB;
            default:                            r_state <= ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            r_state <= (r_cls == CLS_LW) ? ST_WB : ST_FETCH;
          end
        end
        ST_WB:   r_state <= ST_FETCH;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    w_ctrl = '0;
    // ALU controls stay stable from EXEC through WB so the datapath result does not move.
    if (r_state == ST_EXEC || r_state == ST_MEM || r_state == ST_WB) begin
      case (r_cls)
        CLS_ADDU: begin w_ctrl.alu_src = 1'b0; w_ctrl.alu_op = ALU_ADD; end
        CLS_SUBU: begin w_ctrl.alu_src = 1'b0; w_ctrl.alu_op = ALU_SUB; end
        CLS_ORI:  begin w_ctrl.alu_src = 1'b1; w_ctrl.alu_op = ALU_OR;  w_ctrl.ext_op = 1'b0; end
        CLS_LUI:  begin w_ctrl.alu_src = 1'b1; w_ctrl.alu_op = ALU_LUI; end
        CLS_LW, CLS_SW: begin
          w_ctrl.alu_src = 1'b1;
          w_ctrl.alu_op  = ALU_ADD;
          w_ctrl.ext_op  = 1'b1;
        end
        CLS_BEQ:  begin w_ctrl.alu_op = ALU_SUB; w_ctrl.ext_op = 1'b1; end
        default:  ;
      endcase
    end

    case (r_state)
      ST_FETCH: w_ctrl.ir_wr = 1'b1;
      ST_DECODE: begin
        case (w_cls)
          CLS_J: begin
            w_ctrl.jsome = 1'b1;
            w_ctrl.enpc  = 1'b1;
          end
          CLS_JAL: begin
            w_ctrl.jsome   = 1'b1;
            w_ctrl.rf_wr   = 1'b1;
            w_ctrl.reg_dst = RDST_RA;
            w_ctrl.wd_sel  = WD_PC4;
            w_ctrl.enpc    = 1'b1;
          end
          CLS_JR: begin
            w_ctrl.jr   = 1'b1;
            w_ctrl.enpc = 1'b1;
          end
          CLS_ILL: begin
            w_ctrl.illegal = 1'b1;
            w_ctrl.enpc    = 1'b1;
          end
          default: ;
        endcase
      end
      ST_EXEC: begin
        if (r_cls == CLS_BEQ) begin
          w_ctrl.npc_sel = 1'b1;
          w_ctrl.enpc    = 1'b1;
        end
      end
      ST_MEM: begin
        // DM handshake: the request is held until mem_ready; a store retires in that cycle.
        w_ctrl.dm_rd = (r_cls == CLS_LW);
        w_ctrl.dm_wr = (r_cls == CLS_SW);
        w_ctrl.enpc  = (r_cls == CLS_SW) && mem_ready;
      end
      ST_WB: begin
        w_ctrl.rf_wr   = 1'b1;
        w_ctrl.enpc    = 1'b1;
        w_ctrl.reg_dst = cls_is_rtype(r_cls) ? RDST_RD : RDST_RT;
        w_ctrl.wd_sel  = (r_cls == CLS_LW) ? WD_DM : WD_ALU;
      end
      default: ;
    endcase
  end

  // Reset silences every strobe in the very cycle it is asserted, including mid-MEM.
  assign w_out   = reset ? '0 : w_ctrl;
  assign state   = reset ? ST_FETCH : r_state;

  assign enpc    = w_out.enpc;
  assign npc_sel = w_out.npc_sel;
  assign jsome   = w_out.jsome;
  assign jr      = w_out.jr;
  assign ir_wr   = w_out.ir_wr;
  assign rf_wr   = w_out.rf_wr;
  assign reg_dst = w_out.reg_dst;
  assign wd_sel  = w_out.wd_sel;
  assign alu_src = w_out.alu_src;
  assign alu_op  = w_out.alu_op;
  assign ext_op  = w_out.ext_op;
  assign dm_rd   = w_out.dm_rd;
  assign dm_wr   = w_out.dm_wr;
  assign illegal = w_out.illegal;

`ifdef CTRL_PERF_EN
  logic [31:0] r_instr_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_out.enpc) begin
        r_instr_cnt <= r_instr_cnt + 32'd1;
      end
      if (r_state == ST_MEM && !mem_ready) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign instr_cnt = r_instr_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
